// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 serial LED transmitter.
package ws2812_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBitHi,
        StBitLo,
        StLatch
    } state_e;

    // Colour channels per pixel (G, R, B); pixel bit count is this times WIDTH.
    localparam int unsigned ChannelsPerPixel = 3;

    // Widest channel the packing helper supports.
    localparam int unsigned MaxWidth = 32;

    function automatic int unsigned pixel_bits(input int unsigned width);
        return ChannelsPerPixel * width;
    endfunction

    // Pack channels into GRB wire order (green in the most significant slot).
    function automatic logic [ChannelsPerPixel*MaxWidth-1:0] pack_grb(
        input logic [MaxWidth-1:0] g,
        input logic [MaxWidth-1:0] r,
        input logic [MaxWidth-1:0] b,
        input int unsigned         width
    );
        logic [ChannelsPerPixel*MaxWidth-1:0] g_w, r_w, b_w;
        g_w = {{(2*MaxWidth){1'b0}}, g};
        r_w = {{(2*MaxWidth){1'b0}}, r};
        b_w = {{(2*MaxWidth){1'b0}}, b};
        return (g_w << (2 * width)) | (r_w << width) | b_w;
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Loadable down-counter; tc_o marks the last cycle of a loaded duration.
module ws2812_bit_timer #(
    parameter int unsigned CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          tc_o
);

    logic [CW-1:0] count_q, count_d;

    // Load a duration of N cycles, then count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A count of one means the current cycle is the last of the duration.
    assign tc_o = (count_q == CW'(1));

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 single-wire NRZ transmitter: sends one GRB colour to NUM_LEDS pixels,
// then holds the line low for the latch period.
// Build option: define WS2812_AUTO_REFRESH_EN to restart frames back-to-back.
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_LEDS  = 1,
    parameter int unsigned T0H_CYC   = 4,
    parameter int unsigned T1H_CYC   = 8,
    parameter int unsigned BIT_CYC   = 12,
    parameter int unsigned RESET_CYC = 600
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] red,
    input  logic [WIDTH-1:0] green,
    input  logic [WIDTH-1:0] blue,
    input  logic             start,
    output logic             dout,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned PixelBits = pixel_bits(WIDTH);
    localparam int unsigned TimerMax  = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int unsigned TW        = $clog2(TimerMax + 1);
    localparam int unsigned BW        = $clog2(PixelBits);
    localparam int unsigned LW        = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    state_e               state_q, state_d;
    logic [PixelBits-1:0] color_q, color_d;
    logic [PixelBits-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [LW-1:0]        led_q, led_d;
    logic                 dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_tc;
    logic                 accept;
    logic                 frame_end;

    logic [ChannelsPerPixel*MaxWidth-1:0] grb_full;
    logic [PixelBits-1:0]                 grb_in;
    logic                                 unused_grb;

    function automatic logic [TW-1:0] th_of(input logic msb);
        return msb ? TW'(T1H_CYC) : TW'(T0H_CYC);
    endfunction

    // Pack the live inputs; only sampled when a frame is accepted.
    always_comb begin
        grb_full = pack_grb(MaxWidth'(green), MaxWidth'(red), MaxWidth'(blue), WIDTH);
        grb_in   = grb_full[PixelBits-1:0];
    end
    assign unused_grb = ^grb_full;

    ws2812_bit_timer #(
        .CW (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tc_o       (tmr_tc)
    );

    assign frame_end = (state_q == StLatch) && tmr_tc;

    // Frame acceptance: start in idle, or latch exit when auto-refreshing.
`ifdef WS2812_AUTO_REFRESH_EN
    assign accept = ((state_q == StIdle) && start) || frame_end;
`else
    assign accept = (state_q == StIdle) && start;
`endif

    // State register, datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            color_q <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            led_q   <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            led_q   <= led_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, shift/counter updates and timer loads.
    always_comb begin
        state_d  = state_q;
        color_d  = color_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        led_d    = led_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (accept) begin
            color_d  = grb_in;
            shift_d  = grb_in;
            bit_d    = '0;
            led_d    = '0;
            state_d  = StBitHi;
            tmr_load = 1'b1;
            tmr_val  = th_of(grb_in[PixelBits-1]);
        end else begin
            unique case (state_q)
                StIdle: ;
                StBitHi: begin
                    if (tmr_tc) begin
                        state_d  = StBitLo;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(BIT_CYC) - th_of(shift_q[PixelBits-1]);
                    end
                end
                StBitLo: begin
                    if (tmr_tc) begin
                        if (bit_q != BW'(PixelBits - 1)) begin
                            shift_d  = shift_q << 1;
                            bit_d    = bit_q + BW'(1);
                            state_d  = StBitHi;
                            tmr_load = 1'b1;
                            tmr_val  = th_of(shift_q[PixelBits-2]);
                        end else if (led_q != LW'(NUM_LEDS - 1)) begin
                            shift_d  = color_q;
                            bit_d    = '0;
                            led_d    = led_q + LW'(1);
                            state_d  = StBitHi;
                            tmr_load = 1'b1;
                            tmr_val  = th_of(color_q[PixelBits-1]);
                        end else begin
                            state_d  = StLatch;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(RESET_CYC);
                        end
                    end
                end
                StLatch: begin
                    if (tmr_tc) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so dout follows it with no extra lag.
    always_comb begin
        dout_d = (state_d == StBitHi);
        busy_d = (state_d != StIdle);
        done_d = frame_end;
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed self-checking bench for ws2812_tx (one-shot and auto-refresh builds).
module tb_ws2812_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] red, green, blue;
    logic       start0, start1;
    logic       dout0, busy0, fd0;
    logic       dout1, busy1, fd1;

    int checks   = 0;
    int failures = 0;

    logic rd [0:1999];
    logic rb [0:1999];
    logic rf [0:1999];

    always #5 clk = ~clk;

    ws2812_tx u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .start      (start0),
        .dout       (dout0),
        .busy       (busy0),
        .frame_done (fd0)
    );

    ws2812_tx #(
        .NUM_LEDS (2)
    ) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .start      (start1),
        .dout       (dout1),
        .busy       (busy1),
        .frame_done (fd1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Request a frame; returns just after the accepting edge (cycle 0 is next negedge).
    task automatic pulse_start(input int d);
        @(negedge clk);
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Sample n cycles at negedge; optionally switch red to FF and/or pulse start.
    task automatic record(input int d, input int n, input int chg, input int pulse,
                          input bit hold);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd[i] = (d == 0) ? dout0 : dout1;
            rb[i] = (d == 0) ? busy0 : busy1;
            rf[i] = (d == 0) ? fd0 : fd1;
            if (i == chg) red = 8'hFF;
            if (d == 0) start0 = hold || (i == pulse);
            else        start1 = hold || (i == pulse);
        end
    endtask

    task automatic count_ones(input int sel, input int lo, input int hi, output int n);
        n = 0;
        for (int i = lo; i < hi; i++) begin
            if (sel == 0 && rd[i] === 1'b1) n++;
            if (sel == 1 && rb[i] === 1'b1) n++;
            if (sel == 2 && rf[i] === 1'b1) n++;
        end
    endtask

    // Each 12-cycle bit window must be TH high cycles followed by low cycles.
    task automatic check_bits(input int base, input int nleds, input logic [23:0] grb,
                              input string tag);
        int w, th, exp;
        for (int p = 0; p < nleds; p++) begin
            for (int j = 0; j < 24; j++) begin
                w = 0;
                for (int c = 0; c < 12; c++) w = (w << 1) | int'(rd[base + (p*24 + j)*12 + c]);
                th  = grb[23-j] ? 8 : 4;
                exp = ((1 << th) - 1) << (12 - th);
                check($sformatf("%s_p%0d_b%0d", tag, p, j), w, exp);
            end
        end
    endtask

    task automatic check_oneshot(input int nleds, input logic [23:0] grb, input string tag,
                                 input int n);
        int len, cnt;
        len = nleds * 288 + 600;
        check_bits(0, nleds, grb, tag);
        count_ones(1, 0, n, cnt);
        check({tag, "_busy_len"}, cnt, len);
        check({tag, "_busy_end"}, int'(rb[len-1]), 1);
        check({tag, "_done_at_end"}, int'(rf[len]), 1);
        count_ones(2, 0, n, cnt);
        check({tag, "_done_count"}, cnt, 1);
        count_ones(0, nleds * 288, n, cnt);
        check({tag, "_latch_low"}, cnt, 0);
    endtask

    initial begin
        int cnt;
        reset  = 1'b1;
        red    = 8'h00;
        green  = 8'h00;
        blue   = 8'h00;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", int'(dout0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(fd0), 0);
        reset = 1'b0;
        record(0, 20, -1, -1, 1'b0);
        count_ones(0, 0, 20, cnt);
        check("idle_dout", cnt, 0);

        green = 8'hFF;
        red   = 8'h00;
        blue  = 8'hAA;
`ifdef WS2812_AUTO_REFRESH_EN
        // Back-to-back frames; red change at cycle 50 lands in the second frame.
        pulse_start(0);
        record(0, 1800, 50, -1, 1'b0);
        check_bits(0, 1, 24'hFF00AA, "auto_f1");
        check_bits(888, 1, 24'hFFFFAA, "auto_f2");
        check("auto_done_888", int'(rf[888]), 1);
        check("auto_done_1776", int'(rf[1776]), 1);
        count_ones(2, 0, 1800, cnt);
        check("auto_done_count", cnt, 2);
        count_ones(1, 0, 1800, cnt);
        check("auto_busy_const", cnt, 1800);
`else
        pulse_start(0);
        record(0, 950, -1, -1, 1'b0);
        check_oneshot(1, 24'hFF00AA, "single", 950);

        pulse_start(1);
        record(1, 1250, -1, -1, 1'b0);
        check_oneshot(2, 24'hFF00AA, "two_led", 1250);

        // Red changes mid-frame and a start arrives while busy.
        pulse_start(0);
        record(0, 950, 50, 100, 1'b0);
        check_oneshot(1, 24'hFF00AA, "no_tear", 950);

        pulse_start(0);
        record(0, 950, -1, -1, 1'b0);
        check_oneshot(1, 24'hFFFFAA, "next_frame", 950);

        // Start held high: next frame one cycle after frame_done.
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        record(0, 1000, -1, -1, 1'b1);
        check("held_busy_887", int'(rb[887]), 1);
        check("held_busy_888", int'(rb[888]), 0);
        check("held_done_888", int'(rf[888]), 1);
        check("held_dout_889", int'(rd[889]), 1);
        check("held_busy_889", int'(rb[889]), 1);
        start0 = 1'b0;
`endif

        // Reset mid-BIT_HI forces the line low immediately.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse_start(0);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_hi", int'(dout0), 1);
        reset = 1'b1;
        #1;
        check("mid_reset_dout", int'(dout0), 0);
        check("mid_reset_busy", int'(busy0), 0);
        check("mid_reset_done", int'(fd0), 0);
        @(negedge clk);
        reset = 1'b0;
        record(0, 1000, -1, -1, 1'b0);
        count_ones(0, 0, 1000, cnt);
        check("post_reset_dout", cnt, 0);
        count_ones(2, 0, 1000, cnt);
        check("post_reset_done", cnt, 0);
        count_ones(1, 0, 1000, cnt);
        check("post_reset_busy", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
